key_cmd_fsm: RTL
================

KEY_CMD_FSM -- requirements
Module: key_cmd_fsm

Interface
REQ-001 Parameter: TO_CYCLES, default 1000000, max idle cycles allowed in LOAD/WAIT_CR before abort (24-bit counter).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 de_esc, de_validAscii, de_bigD, de_bigE, de_bigL, de_bigP, de_bigS, de_hex, de_cr, de_littlep, de_bigR  in  1 each  single-cycle decoded key strobes from the key decoder.
REQ-006 charData  in  8  same-cycle ASCII byte, used only for the digit value.
REQ-007 ld_time  out  1  one-cycle pulse: ld_val is a validated time.
REQ-008 ld_alarm  out  1  one-cycle pulse: ld_val is a validated alarm.
REQ-009 ld_val  out  16  BCD HHMM, stable from the ld_* pulse until the next load.
REQ-010 alarm_en  out  1  level; set by "E", cleared by "D".
REQ-011 paused  out  1  level; toggled by "P" or "p".
REQ-012 clk_rst  out  1  one-cycle pulse on "R".
REQ-013 cmd_err  out  1  one-cycle pulse on any rejected entry.
REQ-014 busy  out  1  high when state is not IDLE.

Function
REQ-015 States SHALL be IDLE, LOAD, WAIT_CR; a 3-bit digit count dcnt runs 0..4.
REQ-016 In IDLE, "L" SHALL go to LOAD with target=time, "S" SHALL go to LOAD with target=alarm, and both SHALL clear dcnt and the shift register.
REQ-017 In IDLE, "E"/"D"/"P"/"p"/"R" SHALL act next edge; other strobes are ignored (no error).
REQ-018 In LOAD, a digit strobe (de_hex & ~charData[6]) SHALL shift charData[3:0] into the 16-bit register LSB-nibble-first-in and increment dcnt; at dcnt=4 the state becomes WAIT_CR.
REQ-019 In LOAD, hex a-f, de_cr before 4 digits, or any letter strobe SHALL pulse cmd_err and go to IDLE.
REQ-020 In WAIT_CR, de_cr SHALL validate HH<=23 and MM<=59: pass -> ld_time or ld_alarm pulse one cycle after the de_cr edge, ld_val updated that cycle; fail -> cmd_err; either way go to IDLE.
REQ-021 In WAIT_CR, any valid strobe other than de_cr/de_esc SHALL pulse cmd_err and go to IDLE.
REQ-022 de_esc in LOAD/WAIT_CR SHALL abort to IDLE silently (no cmd_err); in IDLE it is ignored.
REQ-023 Outside IDLE, "E"/"D"/"P"/"R" SHALL NOT change alarm_en/paused/clk_rst (handled per REQ-019/021).
REQ-024 The timeout counter SHALL reset on every accepted strobe; on reaching TO_CYCLES in LOAD/WAIT_CR -> cmd_err, IDLE.
REQ-025 Letter/esc/cr/hex strobes SHALL take priority over de_validAscii, which alone is ignored.
REQ-026 All outputs SHALL be registered; pulses SHALL never exceed one cycle; ld_time and ld_alarm SHALL never be high together.

Reset
REQ-027 rst SHALL force IDLE, dcnt=0, shift register=0, ld_val=16'h0000, alarm_en=0, paused=0, timeout=0, and all pulses/busy=0, including mid-entry.
REQ-028 The first strobe after deassertion SHALL be honoured on the first rising edge.

Structure
REQ-029 State encoding, BCD limit constants (23, 59) and TO_CYCLES default SHALL live in the shared lab package.
REQ-030 One sub-module, bcd_time_check (combinational HHMM range check), SHALL be used; the rest is flat.

Verification
REQ-031 "L","1","2","3","4",CR -> ld_time pulse, ld_val=16'h1234, cmd_err=0, busy low after.
REQ-032 "S","2","4","0","0",CR -> cmd_err pulse, no ld_alarm, ld_val unchanged.
REQ-033 "L","0","9",ESC then "E" -> no cmd_err, no load, alarm_en=1.
REQ-034 "L","1","a" -> cmd_err on "a"; then "P","P","p" -> paused=1,0,1.
REQ-035 "L","0","5" then TO_CYCLES idle cycles -> cmd_err exactly once, busy=0.
REQ-036 rst asserted after "S","1","1" -> all outputs 0; following "2","3",CR -> no load, no error.

Source files
------------

// File: rtl/key_cmd_fsm_pkg.sv
// Shared types and constants for the key command FSM: state encoding,
// BCD time limits and the default entry timeout.
package key_cmd_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_CR = 2'd2
  } state_t;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_t;

  localparam int HH_MAX            = 23;
  localparam int MM_MAX            = 59;
  localparam int DIGITS            = 4;
  localparam int TO_WIDTH          = 24;
  localparam int TO_CYCLES_DEFAULT = 1000000;

  function automatic logic [6:0] bcd2bin(input logic [7:0] bcd);
    return 7'(bcd[7:4] * 4'd10 + {3'b000, bcd[3:0]});
  endfunction

endpackage

// File: rtl/key_cmd_fsm_bcd_time_check.sv
// Combinational range check of a BCD HHMM value (00:00 .. 23:59).
module bcd_time_check
  import key_cmd_fsm_pkg::*;
(
  input  logic [15:0] hhmm,
  output logic        ok
);

  logic [6:0] hh;
  logic [6:0] mm;
  logic       digits_ok;

  always_comb begin
    hh        = bcd2bin(hhmm[15:8]);
    mm        = bcd2bin(hhmm[7:0]);
    digits_ok = (hhmm[15:12] <= 4'd9) && (hhmm[11:8] <= 4'd9) &&
                (hhmm[7:4]   <= 4'd9) && (hhmm[3:0]  <= 4'd9);
    ok        = digits_ok && (hh <= 7'(HH_MAX)) && (mm <= 7'(MM_MAX));
  end

endmodule

// File: rtl/key_cmd_fsm.sv
// Keypad command interpreter: L/S + four BCD digits + CR loads time/alarm,
// single-key commands toggle alarm enable, pause and clock reset.
module key_cmd_fsm
  import key_cmd_fsm_pkg::*;
#(
  parameter int TO_CYCLES = TO_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_esc,
  input  logic        de_validAscii,
  input  logic        de_bigD,
  input  logic        de_bigE,
  input  logic        de_bigL,
  input  logic        de_bigP,
  input  logic        de_bigS,
  input  logic        de_hex,
  input  logic        de_cr,
  input  logic        de_littlep,
  input  logic        de_bigR,
  input  logic [7:0]  charData,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic [15:0] ld_val,
  output logic        alarm_en,
  output logic        paused,
  output logic        clk_rst,
  output logic        cmd_err,
  output logic        busy
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_CYCLES - 1);

  state_t              state_reg, state_next;
  target_t             target_reg, target_next;
  logic [2:0]          dcnt_reg, dcnt_next;
  logic [15:0]         sr_reg, sr_next;
  logic [TO_WIDTH-1:0] to_cnt_reg, to_cnt_next;

  logic        ld_time_next, ld_alarm_next, alarm_en_next, paused_next;
  logic        clk_rst_next, cmd_err_next, busy_next;
  logic [15:0] ld_val_next;

  logic letter, digit, hex_alpha, any_strobe, timeout_hit, time_ok;
  logic load_evt, err_evt, in_load, in_wait;
  logic unused_inputs;

  // de_validAscii alone never does anything; only the digit nibble of charData matters
  assign unused_inputs = ^{de_validAscii, charData[7], charData[5:4]};

  assign letter      = de_bigD | de_bigE | de_bigL | de_bigP | de_bigS | de_littlep | de_bigR;
  assign digit       = de_hex & ~charData[6];
  assign hex_alpha   = de_hex & charData[6];
  assign any_strobe  = de_esc | de_cr | de_hex | letter;
  assign in_load     = (state_reg == ST_LOAD);
  assign in_wait     = (state_reg == ST_WAIT_CR);
  assign timeout_hit = (in_load | in_wait) & ~any_strobe & (to_cnt_reg == TO_LAST);

  bcd_time_check u_check (
    .hhmm (sr_reg),
    .ok   (time_ok)
  );

  assign load_evt = in_wait & ~de_esc & de_cr & time_ok;
  assign err_evt  = (in_load & ~de_esc & ~digit & (hex_alpha | de_cr | letter | timeout_hit)) |
                    (in_wait & ~de_esc & ((de_cr & ~time_ok) |
                                          (~de_cr & (de_hex | letter)) | timeout_hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      target_reg <= TGT_TIME;
      dcnt_reg   <= '0;
      sr_reg     <= '0;
      to_cnt_reg <= '0;
      ld_time    <= 1'b0;
      ld_alarm   <= 1'b0;
      ld_val     <= '0;
      alarm_en   <= 1'b0;
      paused     <= 1'b0;
      clk_rst    <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      dcnt_reg   <= dcnt_next;
      sr_reg     <= sr_next;
      to_cnt_reg <= to_cnt_next;
      ld_time    <= ld_time_next;
      ld_alarm   <= ld_alarm_next;
      ld_val     <= ld_val_next;
      alarm_en   <= alarm_en_next;
      paused     <= paused_next;
      clk_rst    <= clk_rst_next;
      cmd_err    <= cmd_err_next;
      busy       <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    dcnt_next   = dcnt_reg;
    sr_next     = sr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (de_bigL || de_bigS) begin
          state_next  = ST_LOAD;
          target_next = de_bigL ? TGT_TIME : TGT_ALARM;
          dcnt_next   = '0;
          sr_next     = '0;
        end
      end
      ST_LOAD: begin
        if (de_esc) begin
          state_next = ST_IDLE;
        end else if (digit) begin
          // first digit typed ends up in the HH tens nibble
          sr_next   = {sr_reg[11:0], charData[3:0]};
          dcnt_next = dcnt_reg + 3'd1;
          if (dcnt_reg == 3'(DIGITS - 1)) state_next = ST_WAIT_CR;
        end else if (hex_alpha || de_cr || letter || timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_CR: begin
        if (de_esc || de_cr || de_hex || letter || timeout_hit) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    to_cnt_next = (state_next == ST_IDLE || any_strobe) ? '0 : to_cnt_reg + 1'b1;
  end

  always_comb begin
    ld_time_next  = 1'b0;
    ld_alarm_next = 1'b0;
    ld_val_next   = ld_val;
    alarm_en_next = alarm_en;
    paused_next   = paused;
    clk_rst_next  = 1'b0;
    cmd_err_next  = err_evt;
    busy_next     = (state_next != ST_IDLE);
    if (load_evt) begin
      ld_val_next = sr_reg;
      if (target_reg == TGT_TIME) ld_time_next = 1'b1;
      else                        ld_alarm_next = 1'b1;
    end
    if (state_reg == ST_IDLE) begin
      if (de_bigE)                   alarm_en_next = 1'b1;
      else if (de_bigD)              alarm_en_next = 1'b0;
      if (de_bigP || de_littlep)     paused_next   = ~paused;
      if (de_bigR)                   clk_rst_next  = 1'b1;
    end
  end

endmodule
